// File: rtl/cache_line_fill_stage.sv
// cache_line_fill_stage: issues AXI line-fill bursts from the address FIFO, writes each returned
// beat into the data array, and updates the tag array for the miss at the head of the miss FIFO.
// Build option: define FILL_RRESP_CHECK_EN to flag non-OKAY read responses in fill_err and
// suppress the tag write of the affected line.
module cache_line_fill_stage #(
    parameter int AXI_ADDR_WDTH = 32,
    parameter int AXI_DATA_WDTH = 512,
    parameter int BEAT_WDTH     = 2,
    parameter int SET_ADDR_WDTH = 7,
    parameter int C_N_WAY       = 4,
    parameter int WAY_WDTH      = 2,
    parameter int TAG_ADDR_WDTH = 16,
    parameter int MAX_OUTST     = 4
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         ar_fifo_empty,
    input  logic [AXI_ADDR_WDTH-1:0]                     ar_fifo_addr,
    output logic                                         ar_fifo_rd_en,
    input  logic                                         miss_fifo_empty,
    input  logic [SET_ADDR_WDTH-1:0]                     miss_set_addr,
    input  logic [C_N_WAY-1:0]                           miss_set_idx,
    input  logic [TAG_ADDR_WDTH-1:0]                     miss_tag,
    output logic                                         miss_fifo_rd_en,
    output logic                                         arvalid,
    input  logic                                         arready,
    output logic [AXI_ADDR_WDTH-1:0]                     araddr,
    output logic [7:0]                                   arlen,
    input  logic                                         rvalid,
    output logic                                         rready,
    input  logic [AXI_DATA_WDTH-1:0]                     rdata,
    input  logic                                         rlast,
    input  logic [1:0]                                   rresp,
    output logic                                         mem_wr_en,
    output logic [SET_ADDR_WDTH+WAY_WDTH+BEAT_WDTH-1:0]  mem_wr_addr,
    output logic [AXI_DATA_WDTH-1:0]                     mem_wr_data,
    output logic                                         tag_wr_en,
    output logic [SET_ADDR_WDTH-1:0]                     tag_wr_set,
    output logic [C_N_WAY-1:0]                           tag_wr_way,
    output logic [TAG_ADDR_WDTH-1:0]                     tag_wr_tag,
    output logic                                         fill_done,
    output logic [2:0]                                   outst_cnt,
    output logic                                         fill_err
);

    localparam int                  MEM_ADDR_W = SET_ADDR_WDTH + WAY_WDTH + BEAT_WDTH;
    localparam logic [BEAT_WDTH-1:0] LAST_BEAT = '1;
    localparam logic [2:0]          OUTST_MAX  = 3'(MAX_OUTST);
    localparam logic [7:0]          ARLEN_LINE = 8'((2 ** BEAT_WDTH) - 1);

    typedef enum logic {IDLE, ADDR} state_t;

    // Lowest set bit wins; an all-zero index falls back to way 0.
    function automatic logic [WAY_WDTH-1:0] way_enc(input logic [C_N_WAY-1:0] idx);
        logic [WAY_WDTH-1:0] w;
        w = '0;
        for (int i = C_N_WAY - 1; i >= 0; i--) begin
            if (idx[i]) w = WAY_WDTH'(i);
        end
        return w;
    endfunction

    // Outstanding-burst count, held inside [0, OUTST_MAX].
    function automatic logic [2:0] outst_next(input logic [2:0] cnt, input logic inc, input logic dec);
        logic [2:0] n;
        n = cnt;
        if (inc && !dec && cnt < OUTST_MAX) n = cnt + 3'd1;
        if (dec && !inc && cnt != 3'd0)     n = cnt - 3'd1;
        return n;
    endfunction

    state_t               state;
    logic [BEAT_WDTH-1:0] beat_cnt;
    logic                 ar_hs_p0;
    logic                 r_hs_p0;
    logic                 rlast_hs_p0;
    logic                 beat_err_p0;
    logic                 idx_err_p0;
    logic                 resp_bad_p0;
    logic                 tag_ok_p0;

    logic                  vld_p1;
    logic                  done_vld_p1;
    logic                  tag_ok_p1;
    logic [MEM_ADDR_W-1:0] wr_addr_p1;
    logic [AXI_DATA_WDTH-1:0] wr_data_p1;
    logic [SET_ADDR_WDTH-1:0] tag_set_p1;
    logic [C_N_WAY-1:0]       tag_way_p1;
    logic [TAG_ADDR_WDTH-1:0] tag_tag_p1;

    // ---- stage p0: handshakes and per-beat checks ----
    assign ar_hs_p0    = arvalid & arready;
    assign rready      = (outst_cnt != 3'd0) & !miss_fifo_empty;
    assign r_hs_p0     = rvalid & rready;
    assign rlast_hs_p0 = r_hs_p0 & rlast;
    assign miss_fifo_rd_en = rlast_hs_p0;
    assign beat_err_p0 = (rlast && beat_cnt != LAST_BEAT) || (!rlast && beat_cnt == LAST_BEAT);
    assign idx_err_p0  = (miss_set_idx == '0);

`ifdef FILL_RRESP_CHECK_EN
    logic line_resp_err;

    assign resp_bad_p0 = r_hs_p0 & (rresp != 2'b00);
    assign tag_ok_p0   = !(line_resp_err | resp_bad_p0);

    // Remember an error response seen earlier in the current line.
    always_ff @(posedge clk) begin
        if (reset)            line_resp_err <= 1'b0;
        else if (rlast_hs_p0) line_resp_err <= 1'b0;
        else if (resp_bad_p0) line_resp_err <= 1'b1;
    end
`else
    logic unused_rresp;

    assign unused_rresp = ^rresp;
    assign resp_bad_p0  = 1'b0;
    assign tag_ok_p0    = 1'b1;
`endif

    // Issue FSM: pop the address FIFO head and hold it on AR until accepted.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            arvalid       <= 1'b0;
            araddr        <= '0;
            arlen         <= '0;
            ar_fifo_rd_en <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ar_fifo_rd_en <= 1'b0;
                    if (!ar_fifo_empty && outst_cnt < OUTST_MAX) begin
                        state         <= ADDR;
                        arvalid       <= 1'b1;
                        araddr        <= ar_fifo_addr;
                        arlen         <= ARLEN_LINE;
                        ar_fifo_rd_en <= 1'b1;
                    end
                end
                ADDR: begin
                    ar_fifo_rd_en <= 1'b0;
                    if (arready) begin
                        arvalid <= 1'b0;
                        state   <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Track bursts issued but not yet closed by rlast.
    always_ff @(posedge clk) begin
        if (reset) outst_cnt <= 3'd0;
        else       outst_cnt <= outst_next(outst_cnt, ar_hs_p0, rlast_hs_p0);
    end

    // Beat position within the line and the sticky error flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt <= '0;
            fill_err <= 1'b0;
        end else if (r_hs_p0) begin
            beat_cnt <= rlast ? '0 : beat_cnt + 1'b1;
            if (beat_err_p0 || idx_err_p0 || resp_bad_p0) fill_err <= 1'b1;
        end
    end

    // ---- stage p1: write strobes ----
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_p1      <= 1'b0;
            done_vld_p1 <= 1'b0;
            tag_ok_p1   <= 1'b0;
        end else begin
            vld_p1      <= r_hs_p0;
            done_vld_p1 <= rlast_hs_p0;
            tag_ok_p1   <= tag_ok_p0;
        end
    end

    // Capture beat data, its array address and the completing miss entry.
    always_ff @(posedge clk) begin
        if (r_hs_p0) begin
            wr_addr_p1 <= {miss_set_addr, way_enc(miss_set_idx), beat_cnt};
            wr_data_p1 <= rdata;
        end
        if (rlast_hs_p0) begin
            tag_set_p1 <= miss_set_addr;
            tag_way_p1 <= miss_set_idx;
            tag_tag_p1 <= miss_tag;
        end
    end

    assign mem_wr_en   = vld_p1;
    assign mem_wr_addr = wr_addr_p1;
    assign mem_wr_data = wr_data_p1;
    assign fill_done   = done_vld_p1;
    assign tag_wr_en   = done_vld_p1 & tag_ok_p1;
    assign tag_wr_set  = tag_set_p1;
    assign tag_wr_way  = tag_way_p1;
    assign tag_wr_tag  = tag_tag_p1;

endmodule

// File: tb/tb_cache_line_fill_stage.sv
// Directed bench for cache_line_fill_stage with small FWFT FIFO models on the AR and miss sides.
module tb_cache_line_fill_stage;

    logic         clk = 1'b0;
    logic         reset;
    logic         ar_fifo_empty;
    logic [31:0]  ar_fifo_addr;
    logic         ar_fifo_rd_en;
    logic         miss_fifo_empty;
    logic [6:0]   miss_set_addr;
    logic [3:0]   miss_set_idx;
    logic [15:0]  miss_tag;
    logic         miss_fifo_rd_en;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic         rvalid;
    logic         rready;
    logic [511:0] rdata;
    logic         rlast;
    logic [1:0]   rresp;
    logic         mem_wr_en;
    logic [10:0]  mem_wr_addr;
    logic [511:0] mem_wr_data;
    logic         tag_wr_en;
    logic [6:0]   tag_wr_set;
    logic [3:0]   tag_wr_way;
    logic [15:0]  tag_wr_tag;
    logic         fill_done;
    logic [2:0]   outst_cnt;
    logic         fill_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cache_line_fill_stage dut (
        .clk(clk), .reset(reset),
        .ar_fifo_empty(ar_fifo_empty), .ar_fifo_addr(ar_fifo_addr), .ar_fifo_rd_en(ar_fifo_rd_en),
        .miss_fifo_empty(miss_fifo_empty), .miss_set_addr(miss_set_addr), .miss_set_idx(miss_set_idx),
        .miss_tag(miss_tag), .miss_fifo_rd_en(miss_fifo_rd_en),
        .arvalid(arvalid), .arready(arready), .araddr(araddr), .arlen(arlen),
        .rvalid(rvalid), .rready(rready), .rdata(rdata), .rlast(rlast), .rresp(rresp),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .tag_wr_en(tag_wr_en), .tag_wr_set(tag_wr_set), .tag_wr_way(tag_wr_way), .tag_wr_tag(tag_wr_tag),
        .fill_done(fill_done), .outst_cnt(outst_cnt), .fill_err(fill_err)
    );

    // FWFT address FIFO model
    logic [31:0] ar_q [0:31];
    int ar_wr = 0;
    int ar_rd = 0;
    assign ar_fifo_empty = (ar_wr == ar_rd);
    assign ar_fifo_addr  = ar_q[ar_rd[4:0]];
    always @(posedge clk) if (ar_fifo_rd_en && !ar_fifo_empty) ar_rd <= ar_rd + 1;

    // FWFT miss FIFO model
    logic [6:0]  ms_set [0:31];
    logic [3:0]  ms_idx [0:31];
    logic [15:0] ms_tag [0:31];
    int ms_wr = 0;
    int ms_rd = 0;
    assign miss_fifo_empty = (ms_wr == ms_rd);
    assign miss_set_addr   = ms_set[ms_rd[4:0]];
    assign miss_set_idx    = ms_idx[ms_rd[4:0]];
    assign miss_tag        = ms_tag[ms_rd[4:0]];
    always @(posedge clk) if (miss_fifo_rd_en && !miss_fifo_empty) ms_rd <= ms_rd + 1;

    int ar_hs_cnt = 0;
    always @(posedge clk) if (arvalid && arready) ar_hs_cnt <= ar_hs_cnt + 1;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chkd(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_ar(input logic [31:0] a);
        ar_q[ar_wr[4:0]] = a;
        ar_wr++;
    endtask

    task automatic push_miss(input logic [6:0] s, input logic [3:0] idx, input logic [15:0] t);
        ms_set[ms_wr[4:0]] = s;
        ms_idx[ms_wr[4:0]] = idx;
        ms_tag[ms_wr[4:0]] = t;
        ms_wr++;
    endtask

    function automatic logic [511:0] pat(input int line, input int b);
        return {16{32'hC0DE0000 | 32'(line * 16 + b)}};
    endfunction

    function automatic logic [10:0] maddr(input logic [6:0] s, input logic [1:0] w, input int b);
        return {s, w, 2'(b)};
    endfunction

    // One R beat: checks rready/pop before the edge, the memory write after it.
    task automatic beat(input string tag, input int line, input int b, input logic last,
                        input logic [1:0] resp, input logic [10:0] exp_addr);
        rvalid = 1'b1;
        rdata  = pat(line, b);
        rlast  = last;
        rresp  = resp;
        #1;
        chk({tag, "_rready"}, 64'(rready), 64'(1));
        chk({tag, "_miss_pop"}, 64'(miss_fifo_rd_en), 64'(last));
        tick();
        chk({tag, "_mem_wr_en"}, 64'(mem_wr_en), 64'(1));
        chk({tag, "_mem_wr_addr"}, 64'(mem_wr_addr), 64'(exp_addr));
        chkd({tag, "_mem_wr_data"}, mem_wr_data, pat(line, b));
        rvalid = 1'b0;
        rlast  = 1'b0;
        rresp  = 2'b00;
    endtask

    // A whole line for one miss entry, ending in rlast on beat nb-1.
    task automatic line(input string tag, input int ln, input logic [6:0] s, input logic [3:0] idx,
                        input logic [1:0] w, input logic [15:0] t, input int nb, input int resp_beat,
                        input logic exp_tag_en);
        push_miss(s, idx, t);
        for (int b = 0; b < nb; b++)
            beat(tag, ln, b, b == nb - 1, (b == resp_beat) ? 2'b10 : 2'b00, maddr(s, w, b));
        chk({tag, "_fill_done"}, 64'(fill_done), 64'(1));
        chk({tag, "_tag_wr_en"}, 64'(tag_wr_en), 64'(exp_tag_en));
        chk({tag, "_tag_set"}, 64'(tag_wr_set), 64'(s));
        chk({tag, "_tag_way"}, 64'(tag_wr_way), 64'(idx));
        chk({tag, "_tag_tag"}, 64'(tag_wr_tag), 64'(t));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int hs0;
        int ms0;
        logic exp_tag_resp;
        logic exp_err_resp;
`ifdef FILL_RRESP_CHECK_EN
        exp_tag_resp = 1'b0;
        exp_err_resp = 1'b1;
`else
        exp_tag_resp = 1'b1;
        exp_err_resp = 1'b0;
`endif
        reset   = 1'b1;
        arready = 1'b0;
        rvalid  = 1'b0;
        rdata   = '0;
        rlast   = 1'b0;
        rresp   = 2'b00;
        tick();
        tick();

        // reset state
        chk("rst_arvalid", 64'(arvalid), 64'(0));
        chk("rst_araddr", 64'(araddr), 64'(0));
        chk("rst_arlen", 64'(arlen), 64'(0));
        chk("rst_rready", 64'(rready), 64'(0));
        chk("rst_ar_pop", 64'(ar_fifo_rd_en), 64'(0));
        chk("rst_mem_wr_en", 64'(mem_wr_en), 64'(0));
        chk("rst_tag_wr_en", 64'(tag_wr_en), 64'(0));
        chk("rst_fill_done", 64'(fill_done), 64'(0));
        chk("rst_outst", 64'(outst_cnt), 64'(0));
        chk("rst_fill_err", 64'(fill_err), 64'(0));
        reset = 1'b0;

        // single miss: addr 0x1000, set 5, way 0b0100, tag 0x00AB
        push_ar(32'h0000_1000);
        arready = 1'b1;
        for (int i = 0; i < 10 && !arvalid; i++) tick();
        chk("t1_arvalid", 64'(arvalid), 64'(1));
        chk("t1_araddr", 64'(araddr), 64'(32'h1000));
        chk("t1_arlen", 64'(arlen), 64'(3));
        tick();
        chk("t1_outst", 64'(outst_cnt), 64'(1));
        chk("t1_arvalid_low", 64'(arvalid), 64'(0));
        line("t1", 1, 7'd5, 4'b0100, 2'd2, 16'h00AB, 4, -1, 1'b1);
        chk("t1_outst_end", 64'(outst_cnt), 64'(0));
        chk("t1_fill_err", 64'(fill_err), 64'(0));
        tick();
        chk("t1_fill_done_pulse", 64'(fill_done), 64'(0));
        chk("t1_tag_wr_en_pulse", 64'(tag_wr_en), 64'(0));
        chk("t1_mem_wr_en_idle", 64'(mem_wr_en), 64'(0));

        // five AR entries, no R traffic: only MAX_OUTST issue
        hs0 = ar_hs_cnt;
        push_ar(32'h0000_2000);
        push_ar(32'h0000_2040);
        push_ar(32'h0000_2080);
        push_ar(32'h0000_20C0);
        push_ar(32'h0000_2100);
        repeat (20) tick();
        chk("t2_ar_hs", 64'(ar_hs_cnt - hs0), 64'(4));
        chk("t2_outst", 64'(outst_cnt), 64'(4));
        chk("t2_ar_pops", 64'(ar_rd), 64'(5));
        chk("t2_araddr_last", 64'(araddr), 64'(32'h20C0));
        chk("t2_arvalid", 64'(arvalid), 64'(0));
        chk("t2_rready_no_miss", 64'(rready), 64'(0));
        line("t2", 2, 7'd6, 4'b0001, 2'd0, 16'h0066, 4, -1, 1'b1);
        chk("t2_outst_after_rlast", 64'(outst_cnt), 64'(3));
        chk("t2_fifth_held", 64'(ar_rd), 64'(5));
        repeat (3) tick();
        chk("t2_fifth_popped", 64'(ar_rd), 64'(6));
        chk("t2_outst_refill", 64'(outst_cnt), 64'(4));
        chk("t2_ar_hs_total", 64'(ar_hs_cnt - hs0), 64'(5));

        // drain two bursts down to outst_cnt 2
        line("t3a", 3, 7'd7, 4'b0010, 2'd1, 16'h0077, 4, -1, 1'b1);
        line("t3b", 4, 7'd9, 4'b1000, 2'd3, 16'h0099, 4, -1, 1'b1);
        chk("t3_outst_drained", 64'(outst_cnt), 64'(2));

        // AR handshake and rlast in the same cycle at outst_cnt 2
        arready = 1'b0;
        push_ar(32'h0000_3000);
        for (int i = 0; i < 10 && !arvalid; i++) tick();
        chk("t3_arvalid", 64'(arvalid), 64'(1));
        chk("t3_araddr", 64'(araddr), 64'(32'h3000));
        push_miss(7'd1, 4'b0001, 16'h0011);
        for (int b = 0; b < 3; b++) beat("t3", 5, b, 1'b0, 2'b00, maddr(7'd1, 2'd0, b));
        chk("t3_ar_stalled", 64'(arvalid), 64'(1));
        arready = 1'b1;
        beat("t3", 5, 3, 1'b1, 2'b00, maddr(7'd1, 2'd0, 3));
        chk("t3_outst_same", 64'(outst_cnt), 64'(2));
        chk("t3_arvalid_low", 64'(arvalid), 64'(0));
        chk("t3_fill_done", 64'(fill_done), 64'(1));

        // error response on beat 1
        line("t4", 6, 7'd2, 4'b0010, 2'd1, 16'h0022, 4, 1, exp_tag_resp);
        chk("t4_fill_err", 64'(fill_err), 64'(exp_err_resp));
        chk("t4_outst", 64'(outst_cnt), 64'(1));

        // rlast on beat 2
        ms0 = ms_rd;
        line("t5", 7, 7'd3, 4'b1000, 2'd3, 16'h0033, 3, -1, 1'b1);
        chk("t5_fill_err", 64'(fill_err), 64'(1));
        chk("t5_miss_popped", 64'(ms_rd - ms0), 64'(1));
        chk("t5_outst", 64'(outst_cnt), 64'(0));
        tick();
        chk("t5_miss_popped_once", 64'(ms_rd - ms0), 64'(1));
        chk("t5_fill_done_pulse", 64'(fill_done), 64'(0));

        // next line starts at beat 0, then reset after its first beat
        push_ar(32'h0000_4000);
        push_miss(7'd4, 4'b0001, 16'h0044);
        for (int i = 0; i < 10 && outst_cnt != 3'd1; i++) tick();
        chk("t6_outst", 64'(outst_cnt), 64'(1));
        beat("t6", 8, 0, 1'b0, 2'b00, maddr(7'd4, 2'd0, 0));
        reset  = 1'b1;
        rvalid = 1'b1;
        rdata  = pat(8, 1);
        tick();
        chk("t6_arvalid", 64'(arvalid), 64'(0));
        chk("t6_araddr", 64'(araddr), 64'(0));
        chk("t6_arlen", 64'(arlen), 64'(0));
        chk("t6_rready", 64'(rready), 64'(0));
        chk("t6_ar_pop", 64'(ar_fifo_rd_en), 64'(0));
        chk("t6_miss_pop", 64'(miss_fifo_rd_en), 64'(0));
        chk("t6_mem_wr_en", 64'(mem_wr_en), 64'(0));
        chk("t6_tag_wr_en", 64'(tag_wr_en), 64'(0));
        chk("t6_fill_done", 64'(fill_done), 64'(0));
        chk("t6_outst", 64'(outst_cnt), 64'(0));
        chk("t6_fill_err", 64'(fill_err), 64'(0));
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rdata = pat(8, 2 + i);
            tick();
            chk("t6_no_mem_wr", 64'(mem_wr_en), 64'(0));
        end
        rvalid = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cache_line_fill_stage.md
CACHE_LINE_FILL_STAGE -- requirements
Module: cache_line_fill_stage

Interface
REQ-001 Parameter AXI_ADDR_WDTH, 32, AXI read address width.
REQ-002 Parameter AXI_DATA_WDTH, 512, AXI read data width; one beat is one memory word.
REQ-003 Parameter BEAT_WDTH, 2, log2 of beats per cache line; arlen = 2**BEAT_WDTH-1.
REQ-004 Parameters SET_ADDR_WDTH 7, C_N_WAY 4 (one-hot way select), WAY_WDTH 2, TAG_ADDR_WDTH 16, MAX_OUTST 4 (outstanding bursts).
REQ-005 clk  in  1  clock; reset  in  1  synchronous, active-high.
REQ-006 ar_fifo_empty  in  1; ar_fifo_addr  in  AXI_ADDR_WDTH  first-word-fall-through head; ar_fifo_rd_en  out  1  pop.
REQ-007 miss_fifo_empty  in  1; miss_set_addr  in  SET_ADDR_WDTH; miss_set_idx  in  C_N_WAY; miss_tag  in  TAG_ADDR_WDTH; miss_fifo_rd_en  out  1.
REQ-008 arvalid  out  1; arready  in  1; araddr  out  AXI_ADDR_WDTH; arlen  out  8.
REQ-009 rvalid  in  1; rready  out  1; rdata  in  AXI_DATA_WDTH; rlast  in  1; rresp  in  2.
REQ-010 mem_wr_en  out  1; mem_wr_addr  out  SET_ADDR_WDTH+WAY_WDTH+BEAT_WDTH  {set,way,beat}; mem_wr_data  out  AXI_DATA_WDTH.
REQ-011 tag_wr_en  out  1; tag_wr_set  out  SET_ADDR_WDTH; tag_wr_way  out  C_N_WAY; tag_wr_tag  out  TAG_ADDR_WDTH; fill_done  out  1  one-cycle pulse per completed line.
REQ-012 outst_cnt  out  3  bursts issued, not yet completed; fill_err  out  1  sticky.

Function
REQ-013 Issue FSM states IDLE, ADDR; IDLE->ADDR when !ar_fifo_empty and outst_cnt<MAX_OUTST, pulsing ar_fifo_rd_en and registering ar_fifo_addr into araddr that cycle.
REQ-014 In ADDR arvalid=1, araddr/arlen stable; ADDR->IDLE on arvalid&arready; no back-to-back issue (at most one AR per two cycles).
REQ-015 outst_cnt +1 on AR handshake, -1 on rlast handshake; both in one cycle leaves it unchanged; never exceeds MAX_OUTST nor underflows.
REQ-016 rready = (outst_cnt!=0) & !miss_fifo_empty; R bursts are in order and belong to the miss FIFO head.
REQ-017 beat_cnt (BEAT_WDTH) increments per R handshake, clears on rlast handshake; wraps to 0.
REQ-018 mem_wr_en asserted one cycle after each R handshake with mem_wr_data=rdata, mem_wr_addr={miss_set_addr, encode(miss_set_idx), beat_cnt} captured at handshake.
REQ-019 On rlast handshake: miss_fifo_rd_en pulses same cycle; next cycle tag_wr_en and fill_done pulse with set/way/tag of the popped entry.
REQ-020 rlast arriving with beat_cnt != all-ones, or beat_cnt all-ones without rlast, sets fill_err; the line still completes on rlast.
REQ-021 miss_set_idx not one-hot: way encodes as lowest set bit; zero encodes as way 0 and sets fill_err.
REQ-022 R handshake with outst_cnt==0 is impossible because rready is low; rvalid alone has no effect.

Reset
REQ-023 reset: FSM IDLE; arvalid, araddr, arlen-hold register, rready, ar_fifo_rd_en, miss_fifo_rd_en, mem_wr_en, tag_wr_en, fill_done, beat_cnt, outst_cnt, fill_err all 0.
REQ-024 reset mid-burst abandons in-flight bursts; no further memory or tag writes until new misses arrive; clearing the external FIFOs is the system's responsibility.

Configuration
REQ-025 Macro FILL_RRESP_CHECK_EN: when defined, any beat with rresp!=0 sets fill_err and the line's tag_wr_en is suppressed (fill_done still pulses); when undefined, rresp is ignored and the tag is always written.

Verification
REQ-026 Single miss: ar addr 0x1000, set 5, way 0b0100, tag 0x00AB; 4 beats -> arlen=3, 4 mem writes addr {5,2,0..3}, tag_wr_en with set 5, way 0b0100, tag 0x00AB, one fill_done.
REQ-027 Five AR entries, arready always 1, rvalid 0 -> exactly 4 AR handshakes, outst_cnt=4, fifth entry not popped until first rlast.
REQ-028 AR handshake and rlast in same cycle at outst_cnt=2 -> outst_cnt stays 2.
REQ-029 rresp=2 on beat 1 -> with FILL_RRESP_CHECK_EN fill_err=1, no tag_wr_en, fill_done=1; without it, tag_wr_en=1, fill_err=0.
REQ-030 rlast on beat 2 -> fill_err=1, miss FIFO popped once, beat_cnt=0 for next line.
REQ-031 reset asserted after beat 1 of 4 -> all outputs 0 next cycle, outst_cnt=0, no further mem_wr_en.
